dtree_seq_eval: RTL
===================

// Module: dtree_seq_eval
// PURPOSE
//  Programmable, sequential decision-tree classifier: successor to the fixed combinational trees.
//  Node table (threshold, feature, children, leaf class) is written at run time; one node is walked per clock.
//  Sits between the feature front-end (valid/ready in) and the class consumer (valid/ready out).
//  Adds a depth guard and error flag that the fixed trees lack.
// PARAMETERS
//  N_FEAT     5   number of input features
//  FEAT_W     8   feature/threshold width, unsigned
//  NODE_AW    6   node address width; table depth = 2**NODE_AW
//  CLASS_W    1   class output width (<= FEAT_W)
//  MAX_DEPTH  16  max internal nodes visited before abort
//  derived: FIDX_W = max(1,$clog2(N_FEAT)); NODE_W = 1+FIDX_W+FEAT_W+2*NODE_AW (24 at defaults)
// PORTS
//  clk        in   1               clock, rising edge
//  rst        in   1               asynchronous reset, active-high
//  in_valid   in   1               feature vector valid
//  in_ready   out  1               block can accept a vector
//  in_feat    in   N_FEAT*FEAT_W   feature i at [i*FEAT_W +: FEAT_W]
//  out_valid  out  1               result valid
//  out_ready  in   1               consumer accepts result
//  out_class  out  CLASS_W         predicted class
//  out_err    out  1               walk aborted (depth or bad feature index)
//  cfg_we     in   1               node table write strobe
//  cfg_addr   in   NODE_AW         node address
//  cfg_data   in   NODE_W          {leaf, fidx, thresh, left, right}, leaf at MSB
//  cfg_busy   out  1               high when not IDLE; cfg_we ignored while high
// BEHAVIOUR
//  Reset: state IDLE; in_ready=1, out_valid=0, out_class=0, out_err=0, cfg_busy=0.
//   Every node entry is reset to leaf=1, all other fields 0 (any tree answers class 0).
//  FSM IDLE -> WALK -> DONE -> IDLE.
//  IDLE: in_ready=1. On in_valid&in_ready: latch in_feat, ptr<=0 (root), depth<=0, go WALK.
//   cfg_we in IDLE writes node[cfg_addr]<=cfg_data at the clock edge.
//   cfg_we and in_valid in the same IDLE cycle: write completes, vector accepted; walk sees the new node.
//  WALK: read node[ptr] combinationally.
//   leaf=1: class<=thresh[CLASS_W-1:0], err<=0, go DONE.
//   leaf=0, fidx>=N_FEAT: class<=0, err<=1, go DONE.
//   leaf=0, depth==MAX_DEPTH: class<=0, err<=1, go DONE (no further node read).
//   else: ptr<=(feat[fidx] <= thresh) ? left : right, unsigned compare; depth<=depth+1.
//  DONE: out_valid=1; out_class/out_err held stable until out_valid&out_ready, then IDLE.
//  Latency: accept at cycle T, k internal nodes on path -> out_valid first high at T+2+k.
//   Leaf at root -> T+2. Worst-case MAX_DEPTH aborts -> T+2+MAX_DEPTH.
//  in_ready=0 in WALK and DONE (one vector in flight). No pipelining of vectors.
//  Child pointers may point anywhere, including loops; depth guard bounds every walk.
//  Async rst mid-walk: immediately IDLE, outputs to reset values, node table reset to defaults.
//  out_valid never drops without out_ready; out_ready while out_valid=0 has no effect.
// TESTING
//  1 Reset then a vector, no config -> out_valid at T+2, class 0, err 0.
//  2 Program root {0,fidx=0,th=21,l=1,r=2}, node1 leaf cls 1, node2 leaf cls 0.
//    X0=21 -> class 1 at T+3. X0=22 -> class 0 at T+3.
//  3 Self-loop at root {0,0,255,0,0} -> err=1, class 0 at T+2+16.
//  4 Root fidx=7 (N_FEAT=5) -> err=1 at T+2.
//  5 Hold out_ready=0 for 10 cycles -> out_valid/class stable, in_ready=0, cfg_we ignored.
//    Then handshake -> IDLE next cycle.
//  6 Assert rst during WALK at depth 3 -> out_valid=0, in_ready=1 immediately.
//    Node table reverts; next vector -> class 0.

Source files
------------

// File: rtl/dtree_seq_eval_if.sv
// Handshake and configuration bundle for the sequential decision-tree classifier.
// master drives vectors/config and consumes results; slave is the classifier.
interface dtree_seq_eval_if #(
  parameter int N_FEAT  = 5,
  parameter int FEAT_W  = 8,
  parameter int NODE_AW = 6,
  parameter int CLASS_W = 1
);
  localparam int FIDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam int NODE_W = 1 + FIDX_W + FEAT_W + 2 * NODE_AW;

  logic                     in_valid;
  logic                     in_ready;
  logic [N_FEAT*FEAT_W-1:0] in_feat;
  logic                     out_valid;
  logic                     out_ready;
  logic [CLASS_W-1:0]       out_class;
  logic                     out_err;
  logic                     cfg_we;
  logic [NODE_AW-1:0]       cfg_addr;
  logic [NODE_W-1:0]        cfg_data;
  logic                     cfg_busy;

  modport master (
    output in_valid, in_feat, out_ready, cfg_we, cfg_addr, cfg_data,
    input  in_ready, out_valid, out_class, out_err, cfg_busy
  );

  modport slave (
    input  in_valid, in_feat, out_ready, cfg_we, cfg_addr, cfg_data,
    output in_ready, out_valid, out_class, out_err, cfg_busy
  );
endinterface

// File: rtl/dtree_seq_eval.sv
// Programmable decision-tree classifier walking one node per clock from a
// run-time written node table, with a depth guard and an error flag.
module dtree_seq_eval #(
  parameter int N_FEAT    = 5,
  parameter int FEAT_W    = 8,
  parameter int NODE_AW   = 6,
  parameter int CLASS_W   = 1,
  parameter int MAX_DEPTH = 16
) (
  input logic               clk,
  input logic               rst,
  dtree_seq_eval_if.slave   bus
);
  localparam int FIDX_W  = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam int NODE_W  = 1 + FIDX_W + FEAT_W + 2 * NODE_AW;
  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);
  localparam int N_NODES = 2 ** NODE_AW;

  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

  state_t                   state, state_nxt;
  logic [NODE_W-1:0]        nodes [N_NODES];
  logic [N_FEAT*FEAT_W-1:0] feat_q;
  logic [NODE_AW-1:0]       ptr;
  logic [DEPTH_W-1:0]       depth;
  logic [CLASS_W-1:0]       class_q;
  logic                     err_q;

  logic [NODE_W-1:0]  node;
  logic               node_leaf;
  logic [FIDX_W-1:0]  node_fidx;
  logic [FEAT_W-1:0]  node_thresh;
  logic [NODE_AW-1:0] node_left;
  logic [NODE_AW-1:0] node_right;
  logic [FEAT_W-1:0]  sel_feat;
  logic               bad_fidx;
  logic               depth_hit;

  assign node        = nodes[ptr];
  assign node_right  = node[NODE_AW-1:0];
  assign node_left   = node[2*NODE_AW-1:NODE_AW];
  assign node_thresh = node[2*NODE_AW+FEAT_W-1:2*NODE_AW];
  assign node_fidx   = node[2*NODE_AW+FEAT_W+FIDX_W-1:2*NODE_AW+FEAT_W];
  assign node_leaf   = node[NODE_W-1];
  assign bad_fidx    = {1'b0, node_fidx} >= (FIDX_W + 1)'(N_FEAT);
  assign depth_hit   = depth == DEPTH_W'(MAX_DEPTH);

  // Feature mux; out-of-range indices fall to zero and are flagged separately.
  always_comb begin
    sel_feat = '0;
    for (int i = 0; i < N_FEAT; i++) begin
      if (node_fidx == FIDX_W'(i)) sel_feat = feat_q[i*FEAT_W +: FEAT_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = WALK;
      WALK:    if (node_leaf || bad_fidx || depth_hit) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Table writes are only honoured in IDLE so a walk never sees a half-changed tree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_NODES; i++) nodes[i] <= {1'b1, {(NODE_W-1){1'b0}}};
    end else if (state == IDLE && bus.cfg_we) begin
      nodes[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      feat_q  <= '0;
      ptr     <= '0;
      depth   <= '0;
      class_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            feat_q <= bus.in_feat;
            ptr    <= '0;
            depth  <= '0;
          end
        end
        WALK: begin
          if (node_leaf) begin
            class_q <= node_thresh[CLASS_W-1:0];
            err_q   <= 1'b0;
          end else if (bad_fidx || depth_hit) begin
            class_q <= '0;
            err_q   <= 1'b1;
          end else begin
            ptr   <= (sel_feat <= node_thresh) ? node_left : node_right;
            depth <= depth + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.cfg_busy  = (state != IDLE);
  assign bus.out_class = class_q;
  assign bus.out_err   = err_q;
endmodule
